seg_scan_driver: RTL and testbench

//  Downstream display stage for the 4-bit ripple adder: captures operands and {carry,sum}
//  on a load strobe, then time-multiplexes four common-anode seven-segment digits.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_hex_decode.sv | 30 +++
 rtl/seg_scan_driver.sv | 62 ++++++
 tb/tb_seg_scan_driver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: active-low seven-segment glyphs (seg[6]=a .. seg[0]=g), anode-off pattern, digit index type.
package seg_pkg;
  typedef logic [1:0] digit_t;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational 4-bit hex value to active-low seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] glyph
);
  always_comb begin
    glyph = SEG_OFF;
    case (value)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'ha: glyph = SEG_A;
      4'hb: glyph = SEG_B;
      4'hc: glyph = SEG_C;
      4'hd: glyph = SEG_D;
      4'he: glyph = SEG_E;
      4'hf: glyph = SEG_F;
      default: glyph = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: captures adder operands/result and scans four common-anode digits (A, B, tens, ones).
// Define SEG_BLANK_EN to blank all anodes for the first BLANK_CYCLES of every digit slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sum,
  input  logic       co,
  output logic [6:0] seg,
  output logic [3:0] an
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  logic [3:0] held_a, held_b, ones, nib;
  logic [4:0] held_r;
  logic [1:0] tens;
  logic [CW-1:0] cnt;
  digit_t dig;
  logic [6:0] glyph, seg_d;
  logic [3:0] an_d;
  logic wrap, blank;
  assign wrap = cnt == CW'(DIGIT_CYCLES - 1);
`ifdef SEG_BLANK_EN
  assign blank = cnt < CW'(BLANK_CYCLES);
`else
  assign blank = 1'b0;
`endif
  // Compare ladder instead of a divider; result never exceeds 31.
  always_comb begin
    tens = held_r >= 5'd30 ? 2'd3 : held_r >= 5'd20 ? 2'd2 : held_r >= 5'd10 ? 2'd1 : 2'd0;
    ones = 4'(held_r - 5'(tens) * 5'd10);
    nib = dig == 2'd3 ? held_a : dig == 2'd2 ? held_b : dig == 2'd1 ? {2'b00, tens} : ones;
  end
  seg_hex_decode u_dec (.value(nib), .glyph(glyph));
  always_comb begin
    seg_d = (blank || (dig == 2'd1 && tens == 2'd0)) ? SEG_OFF : glyph;
    an_d = blank ? AN_OFF : ~(4'b0001 << dig);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_a <= '0;
      held_b <= '0;
      held_r <= '0;
      cnt <= '0;
      dig <= '0;
      seg <= SEG_OFF;
      an <= AN_OFF;
    end else begin
      if (load) {held_a, held_b, held_r} <= {a, b, co, sum};
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) dig <= dig + 2'd1;
      seg <= seg_d;
      an <= an_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of seg_scan_driver against a cycle-count reference model.
module tb_seg_scan_driver;
  localparam int DC = 4;
`ifdef SEG_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, load = 0, co = 0;
  logic [3:0] a = 0, b = 0, sum = 0;
  logic [6:0] seg;
  logic [3:0] an;
  int tests = 0, fails = 0;
  seg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load(load), .a(a), .b(b), .sum(sum), .co(co), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  logic [6:0] glyph_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  // Reference: n edges since reset; digit = (n/DC)%4, slot position = n%DC, decimal split by / and %.
  int n, ma, mb, mr, md, ms, mt, mv;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0; ma <= 0; mb <= 0; mr <= 0;
      exp_an <= 4'b1111; exp_seg <= 7'b1111111;
    end else begin
      md = (n / DC) % 4;
      ms = n % DC;
      mt = mr / 10;
      mv = md == 3 ? ma : md == 2 ? mb : md == 1 ? mt : mr % 10;
      exp_an <= (BLANK_EN && ms < 1) ? 4'b1111 : ~(4'b0001 << md);
      exp_seg <= ((BLANK_EN && ms < 1) || (md == 1 && mt == 0)) ? 7'b1111111 : glyph_tab[mv];
      if (load) begin ma <= int'(a); mb <= int'(b); mr <= int'({co, sum}); end
      n <= n + 1;
    end
  end

  task test_reset;
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (an !== 4'b1111 || seg !== 7'b1111111) begin
        fails++; $display("FAIL reset_hold an=%b seg=%b want 1111/1111111", an, seg);
      end
    end
    rst = 0;
    @(negedge clk);
    tests++;
    if (an !== (BLANK_EN ? 4'b1111 : 4'b1110)) begin
      fails++; $display("FAIL reset_first_an an=%b want %b", an, BLANK_EN ? 4'b1111 : 4'b1110);
    end
    if (BLANK_EN) begin
      @(negedge clk);
      tests++;
      if (an !== 4'b1110) begin fails++; $display("FAIL reset_first_driven an=%b want 1110", an); end
    end
  endtask

  task test_cadence;
    logic [3:0] want;
    rst = 1; @(negedge clk); rst = 0;
    for (int k = 0; k < 4 * DC + 4; k++) begin
      @(negedge clk);
      want = (BLANK_EN && k % DC == 0) ? 4'b1111 : ~(4'b0001 << ((k / DC) % 4));
      tests++;
      if (an !== want) begin fails++; $display("FAIL cadence k=%0d an=%b want %b", k, an, want); end
      if (!BLANK_EN && an === 4'b1111) begin fails++; $display("FAIL cadence_dark k=%0d", k); end
    end
  endtask

  task test_digits;
    int va[3] = '{7, 3, 15};
    int vb[3] = '{9, 4, 15};
    int vs[3] = '{0, 7, 14};
    int vc[3] = '{1, 0, 1};
    logic [27:0] g[3] = '{{7'b0001111, 7'b0000100, 7'b1001111, 7'b0100000},
                          {7'b0000110, 7'b1001100, 7'b1111111, 7'b0001111},
                          {7'b0111000, 7'b0111000, 7'b0000110, 7'b0000001}};
    logic [27:0] cur;
    int d, seen;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      load = 1; a = 4'(va[v]); b = 4'(vb[v]); sum = 4'(vs[v]); co = vc[v][0];
      @(negedge clk);
      load = 0;
      @(negedge clk);
      cur = g[v];
      seen = 0;
      for (int k = 0; k < 4 * DC; k++) begin
        @(negedge clk);
        if (an !== 4'b1111) begin
          d = !an[0] ? 0 : !an[1] ? 1 : !an[2] ? 2 : 3;
          seen = seen | (1 << d);
          tests++;
          if ($countones(~an) != 1) begin fails++; $display("FAIL onehot v=%0d an=%b", v, an); end
          tests++;
          if (seg !== cur[d*7 +: 7]) begin
            fails++; $display("FAIL digit v=%0d d=%0d seg=%b want %b", v, d, seg, cur[d*7 +: 7]);
          end
        end
      end
      tests++;
      if (seen != 15) begin fails++; $display("FAIL digits_seen v=%0d got %b want 1111", v, 4'(seen)); end
    end
  endtask

  task test_random;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      tests++;
      if (an !== exp_an || seg !== exp_seg) begin
        fails++; $display("FAIL random k=%0d an=%b seg=%b want %b/%b", k, an, seg, exp_an, exp_seg);
      end
      load = ($urandom_range(0, 3) == 0);
      a = 4'($urandom); b = 4'($urandom); sum = 4'($urandom); co = 1'($urandom);
    end
    @(negedge clk);
    load = 1; a = 4'hc; b = 4'h5; sum = 4'h9; co = 1;
    @(negedge clk);
    load = 0;
  endtask

  task test_reset_mid;
    int k;
    k = 0;
    while (an !== 4'b1011 && k < 40) begin @(negedge clk); k++; end
    tests++;
    if (an !== 4'b1011) begin fails++; $display("FAIL reset_mid_wait an=%b never reached 1011", an); end
    #2 rst = 1;
    #1;
    tests++;
    if (an !== 4'b1111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL reset_mid_async an=%b seg=%b want 1111/1111111", an, seg);
    end
    @(negedge clk);
    rst = 0;
    for (int j = 0; j < 4 * DC; j++) begin
      @(negedge clk);
      tests++;
      if (an !== exp_an || seg !== exp_seg) begin
        fails++; $display("FAIL reset_mid_scan j=%0d an=%b seg=%b want %b/%b", j, an, seg, exp_an, exp_seg);
      end
      if (j == (BLANK_EN ? 1 : 0)) begin
        tests++;
        if (an !== 4'b1110 || seg !== 7'b0000001) begin
          fails++; $display("FAIL reset_mid_restart an=%b seg=%b want 1110/0000001", an, seg);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_cadence;
    test_digits;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
